// File: rtl/riscv_nn_rf_pkg.sv
// Shared types and helpers for the multi-port NN register file.
// Contents: default sizing localparams, the write-stage slot payload
// (sized to package-level maximums; modules cast down to their own widths),
// and prio_select(), which resolves same-address write slots to the
// highest-index port.
package riscv_nn_rf_pkg;

  localparam int unsigned RF_NUM_WORDS  = 32;
  localparam int unsigned RF_DATA_WIDTH = 32;
  localparam int unsigned RF_NUM_READ   = 3;
  localparam int unsigned RF_NUM_WRITE  = 2;
  localparam int unsigned RF_ZERO_REG   = 1;

  // Upper bounds for any instance: up to 256 words, 64-bit data, 4 write ports.
  localparam int unsigned RF_MAX_ADDR_W = 8;
  localparam int unsigned RF_MAX_DATA_W = 64;
  localparam int unsigned RF_MAX_WRITE  = 4;

  typedef struct packed {
    logic                     valid;
    logic [RF_MAX_ADDR_W-1:0] addr;
    logic [RF_MAX_DATA_W-1:0] data;
  } rf_wstage_t;

  typedef rf_wstage_t [RF_MAX_WRITE-1:0] rf_wstage_vec_t;

  // Index of the highest-numbered valid slot targeting addr, or -1 if none.
  function automatic int prio_select(input rf_wstage_vec_t slots,
                                     input logic [RF_MAX_ADDR_W-1:0] addr);
    int sel;
    sel = -1;
    for (int i = 0; i < int'(RF_MAX_WRITE); i++) begin
      if (slots[i].valid && (slots[i].addr == addr)) sel = i;
    end
    return sel;
  endfunction

endpackage

// File: rtl/riscv_nn_rf_scoreboard.sv
// Per-register pending scoreboard for long-latency writebacks.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   rsv_valid_i/addr  reserve request from issue
//   flush_i           drop every reservation
//   clr_i             one-hot-ish clear mask (registers whose data becomes readable)
//   pending_o         pending bit per entry
//   rsv_ready_o       reservation for rsv_addr_i can be accepted (combinational)
// Precedence at a posedge: flush > set (accepted reserve) > clear.
module riscv_nn_rf_scoreboard
  import riscv_nn_rf_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = RF_NUM_WORDS,
  parameter  int unsigned ZERO_REG   = RF_ZERO_REG,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0] rsv_addr_i,
  input  logic                  flush_i,
  input  logic [NUM_WORDS-1:0]  clr_i,
  output logic [NUM_WORDS-1:0]  pending_o,
  output logic                  rsv_ready_o
);

  logic [NUM_WORDS-1:0] pending_d, pending_q;
  logic                 zero_addr;
  logic                 accept;

  // Next pending state; a reservation on the hard-wired zero entry is a no-op.
  always_comb begin
    zero_addr   = (ZERO_REG != 0) && (rsv_addr_i == '0);
    rsv_ready_o = !pending_q[rsv_addr_i] || zero_addr;
    accept      = rsv_valid_i && rsv_ready_o && !flush_i;
    pending_d   = pending_q & ~clr_i;
    if (accept)         pending_d[rsv_addr_i] = 1'b1;
    if (flush_i)        pending_d             = '0;
    if (ZERO_REG != 0)  pending_d[0]          = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/riscv_nn_register_file_mp.sv
// Parametrised multi-port flip-flop register file with a registered write
// stage and a pending scoreboard for long-latency producers.
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   raddr_i/rdata_o/rbusy_o    NUM_READ combinational read ports + pending hint
//   waddr_i/wdata_i/we_i       NUM_WRITE write ports (higher index wins)
//   rsv_valid_i/rsv_addr_i     reserve a register at issue
//   rsv_ready_o                reservation acceptable this cycle
//   flush_i                    drop all reservations (writes still commit)
// Optional build macro: RISCV_NN_RF_BYPASS_EN forwards stage slots to the
// read ports, making writes visible one cycle earlier and clearing pending at
// the sampling edge instead of the commit edge.
module riscv_nn_register_file_mp
  import riscv_nn_rf_pkg::*;
#(
  parameter  int unsigned NUM_WORDS  = RF_NUM_WORDS,
  parameter  int unsigned DATA_WIDTH = RF_DATA_WIDTH,
  parameter  int unsigned NUM_READ   = RF_NUM_READ,
  parameter  int unsigned NUM_WRITE  = RF_NUM_WRITE,
  parameter  int unsigned ZERO_REG   = RF_ZERO_REG,
  localparam int unsigned ADDR_WIDTH = $clog2(NUM_WORDS)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_READ-1:0][ADDR_WIDTH-1:0]  raddr_i,
  output logic [NUM_READ-1:0][DATA_WIDTH-1:0]  rdata_o,
  output logic [NUM_READ-1:0]                  rbusy_o,
  input  logic [NUM_WRITE-1:0][ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WRITE-1:0][DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WRITE-1:0]                 we_i,
  input  logic                                 rsv_valid_i,
  input  logic [ADDR_WIDTH-1:0]                rsv_addr_i,
  output logic                                 rsv_ready_o,
  input  logic                                 flush_i
);

  rf_wstage_vec_t        wcand;
  rf_wstage_vec_t        stage_d, stage_q;
  logic [DATA_WIDTH-1:0] array_d [NUM_WORDS];
  logic [DATA_WIDTH-1:0] array_q [NUM_WORDS];
  logic [NUM_WORDS-1:0]  pend_clr;
  logic [NUM_WORDS-1:0]  pending;
  logic                  sb_ready;
`ifdef RISCV_NN_RF_BYPASS_EN
  int                    byp_sel;
`endif

  // Sample write ports; same-address losers are dropped here so commit never sees duplicates.
  always_comb begin
    wcand   = '0;
    stage_d = '0;
    for (int unsigned p = 0; p < NUM_WRITE; p++) begin
      wcand[p].valid = we_i[p] && !((ZERO_REG != 0) && (waddr_i[p] == '0));
      wcand[p].addr  = RF_MAX_ADDR_W'(waddr_i[p]);
      wcand[p].data  = RF_MAX_DATA_W'(wdata_i[p]);
    end
    for (int p = 0; p < int'(RF_MAX_WRITE); p++) begin
      if (wcand[p].valid && (prio_select(wcand, wcand[p].addr) == p)) stage_d[p] = wcand[p];
    end
  end

  // Commit stage slots into the array; ascending order keeps the highest port last.
  always_comb begin
    array_d = array_q;
    for (int p = 0; p < int'(RF_MAX_WRITE); p++) begin
      if (stage_q[p].valid) array_d[ADDR_WIDTH'(stage_q[p].addr)] = DATA_WIDTH'(stage_q[p].data);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stage_q <= '0;
      array_q <= '{default: '0};
    end else begin
      stage_q <= stage_d;
      array_q <= array_d;
    end
  end

  // Pending clears on the edge after which the new data is readable.
  always_comb begin
    pend_clr = '0;
    for (int p = 0; p < int'(RF_MAX_WRITE); p++) begin
`ifdef RISCV_NN_RF_BYPASS_EN
      if (stage_d[p].valid) pend_clr[ADDR_WIDTH'(stage_d[p].addr)] = 1'b1;
`else
      if (stage_q[p].valid) pend_clr[ADDR_WIDTH'(stage_q[p].addr)] = 1'b1;
`endif
    end
  end

  riscv_nn_rf_scoreboard #(
    .NUM_WORDS (NUM_WORDS),
    .ZERO_REG  (ZERO_REG)
  ) u_scoreboard (
    .clk         (clk),
    .rst_n       (rst_n),
    .rsv_valid_i (rsv_valid_i),
    .rsv_addr_i  (rsv_addr_i),
    .flush_i     (flush_i),
    .clr_i       (pend_clr),
    .pending_o   (pending),
    .rsv_ready_o (sb_ready)
  );

  // Combinational read ports; outputs held at their reset values while rst_n is low.
  always_comb begin
`ifdef RISCV_NN_RF_BYPASS_EN
    byp_sel = -1;
`endif
    for (int unsigned r = 0; r < NUM_READ; r++) begin
      rdata_o[r] = array_q[raddr_i[r]];
`ifdef RISCV_NN_RF_BYPASS_EN
      byp_sel = prio_select(stage_q, RF_MAX_ADDR_W'(raddr_i[r]));
      for (int p = 0; p < int'(RF_MAX_WRITE); p++) begin
        if (byp_sel == p) rdata_o[r] = DATA_WIDTH'(stage_q[p].data);
      end
`endif
      if (!rst_n || ((ZERO_REG != 0) && (raddr_i[r] == '0))) rdata_o[r] = '0;
      rbusy_o[r] = rst_n && pending[raddr_i[r]];
    end
  end

  assign rsv_ready_o = !rst_n || sb_ready;

endmodule

// File: tb/tb_riscv_nn_register_file_mp.sv
module tb_riscv_nn_register_file_mp;

`ifdef RISCV_NN_RF_BYPASS_EN
  localparam int LAT = 1;
  localparam bit BYP = 1'b1;
`else
  localparam int LAT = 2;
  localparam bit BYP = 1'b0;
`endif

  logic             clk;
  logic             rst_n;
  logic [2:0][4:0]  raddr;
  logic [2:0][31:0] rdata_o;
  logic [2:0]       rbusy_o;
  logic [1:0][4:0]  waddr;
  logic [1:0][31:0] wdata;
  logic [1:0]       we;
  logic             rsv_valid;
  logic [4:0]       rsv_addr;
  logic             rsv_ready_o;
  logic             flush;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  riscv_nn_register_file_mp dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .raddr_i     (raddr),
    .rdata_o     (rdata_o),
    .rbusy_o     (rbusy_o),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .we_i        (we),
    .rsv_valid_i (rsv_valid),
    .rsv_addr_i  (rsv_addr),
    .rsv_ready_o (rsv_ready_o),
    .flush_i     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  // Reference model: architectural contents, busy set, and in-flight writes with visibility time.
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
    int          due;
  } wr_t;

  logic [31:0] m_mem  [32];
  bit          m_busy [32];
  wr_t         inflight[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
    end
  endtask

  task automatic model_check();
    for (int r = 0; r < 3; r++) begin
      logic [31:0] er;
      logic        eb;
      er = (!rst_n || raddr[r] == 5'd0) ? 32'h0 : m_mem[raddr[r]];
      eb = rst_n && m_busy[raddr[r]];
      check($sformatf("model_rdata%0d", r), rdata_o[r], er);
      check($sformatf("model_rbusy%0d", r), 32'(rbusy_o[r]), 32'(eb));
    end
    check("model_rsv_ready", 32'(rsv_ready_o),
          32'(!rst_n || !m_busy[rsv_addr] || rsv_addr == 5'd0));
  endtask

  task automatic model_update();
    bit  rdy;
    bit  clr [32];
    wr_t keep[$];
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_mem[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
      inflight.delete();
      cyc++;
      return;
    end
    rdy = !m_busy[rsv_addr] || rsv_addr == 5'd0;
    for (int p = 0; p < 2; p++) begin
      if (we[p] && waddr[p] != 5'd0) inflight.push_back('{waddr[p], wdata[p], cyc + LAT});
    end
    for (int i = 0; i < 32; i++) clr[i] = 1'b0;
    foreach (inflight[i]) begin
      if (inflight[i].due == cyc + 1) begin
        m_mem[inflight[i].a] = inflight[i].d;
        clr[inflight[i].a]   = 1'b1;
      end else begin
        keep.push_back(inflight[i]);
      end
    end
    inflight = keep;
    for (int i = 0; i < 32; i++) if (clr[i]) m_busy[i] = 1'b0;
    if (flush) begin
      for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    end else if (rsv_valid && rdy && rsv_addr != 5'd0) begin
      m_busy[rsv_addr] = 1'b1;
    end
    cyc++;
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  // Directed vector: one cycle of inputs plus the expected port-0 / reserve outputs.
  typedef struct {
    bit        rst;
    bit [1:0]  we;
    bit [4:0]  wa0;
    bit [31:0] wd0;
    bit [4:0]  wa1;
    bit [31:0] wd1;
    bit [4:0]  ra;
    bit        rv;
    bit [4:0]  rsa;
    bit        fl;
    bit [31:0] erd;
    bit        ebz;
    bit        erdy;
  } vec_t;

  function automatic vec_t mk(input int unsigned rst, input int unsigned wev,
                              input int unsigned wa0, input int unsigned wd0,
                              input int unsigned wa1, input int unsigned wd1,
                              input int unsigned ra, input int unsigned rv,
                              input int unsigned rsa, input int unsigned fl,
                              input int unsigned erd, input int unsigned ebz,
                              input int unsigned erdy);
    vec_t v;
    v.rst = 1'(rst);  v.we = 2'(wev);
    v.wa0 = 5'(wa0);  v.wd0 = wd0;
    v.wa1 = 5'(wa1);  v.wd1 = wd1;
    v.ra  = 5'(ra);   v.rv  = 1'(rv);
    v.rsa = 5'(rsa);  v.fl  = 1'(fl);
    v.erd = erd;      v.ebz = 1'(ebz);
    v.erdy = 1'(erdy);
    return v;
  endfunction

  vec_t vecs[$];

  initial begin
    rst_n = 1'b0; raddr = '0; waddr = '0; wdata = '0; we = '0;
    rsv_valid = 1'b0; rsv_addr = '0; flush = 1'b0;
    for (int i = 0; i < 32; i++) begin m_mem[i] = 32'h0; m_busy[i] = 1'b0; end

    //        rst we wa0 wd0            wa1 wd1            ra rv        rsa fl  erd                           ebz          erdy
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        0, 0,        9, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 1, 5, 32'hDEADBEEF, 0, 32'h0,        5, 0,        9, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        5, 0,        9, 0, BYP ? 32'hDEADBEEF : 32'h0,   0,           1));
    vecs.push_back(mk(1, 3, 7, 32'h11111111, 7, 32'h22222222, 5, 0,        9, 0, 32'hDEADBEEF,                 0,           1));
    vecs.push_back(mk(1, 1, 0, 32'hFFFFFFFF, 0, 32'h0,        7, 0,        9, 0, BYP ? 32'h22222222 : 32'h0,   0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        7, 0,        9, 0, 32'h22222222,                 0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        0, 1,        9, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        9, 0,        9, 0, 32'h0,                        1,           0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        9, 0,        9, 0, 32'h0,                        1,           0));
    vecs.push_back(mk(1, 1, 9, 32'h99,       0, 32'h0,        9, 0,        9, 0, 32'h0,                        1,           0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        9, 0,        9, 0, BYP ? 32'h99 : 32'h0,         BYP ? 0 : 1, BYP ? 1 : 0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        9, 0,        9, 0, 32'h99,                       0,           1));
    vecs.push_back(mk(1, 1, 3, 32'h33,       0, 32'h0,        3, BYP,      3, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        3, BYP ? 0 : 1, 3, 0, BYP ? 32'h33 : 32'h0,     BYP ? 1 : 0, BYP ? 0 : 1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        3, 0,        3, 0, 32'h33,                       1,           0));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        3, 1,        4, 1, 32'h33,                       1,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        3, 0,        4, 0, 32'h33,                       0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        4, 0,        4, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 1, 12, 32'h0000000C, 0, 32'h0,       12, 0,       4, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(0, 0, 0, 32'h0,        0, 32'h0,        12, 0,       4, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        12, 0,       4, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        12, 0,       4, 0, 32'h0,                        0,           1));
    vecs.push_back(mk(1, 0, 0, 32'h0,        0, 32'h0,        5, 0,        4, 0, 32'h0,                        0,           1));

    @(negedge clk);
    // Reset, then sweep every address on all read ports.
    for (int i = 0; i < 2; i++) begin
      #1; model_check(); advance();
    end
    rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      for (int r = 0; r < 3; r++) raddr[r] = 5'(a);
      rsv_addr = 5'(a);
      #1;
      check($sformatf("sweep_rdata_a%0d", a), rdata_o[0], 32'h0);
      check($sformatf("sweep_rbusy_a%0d", a), 32'(rbusy_o[2]), 32'h0);
      check($sformatf("sweep_ready_a%0d", a), 32'(rsv_ready_o), 32'h1);
      model_check();
      advance();
    end

    // Directed multi-cycle sequences.
    foreach (vecs[i]) begin
      rst_n     = vecs[i].rst;
      we        = vecs[i].we;
      waddr[0]  = vecs[i].wa0; wdata[0] = vecs[i].wd0;
      waddr[1]  = vecs[i].wa1; wdata[1] = vecs[i].wd1;
      for (int r = 0; r < 3; r++) raddr[r] = vecs[i].ra;
      rsv_valid = vecs[i].rv;
      rsv_addr  = vecs[i].rsa;
      flush     = vecs[i].fl;
      #1;
      check($sformatf("tbl%0d_rdata", i), rdata_o[0], vecs[i].erd);
      check($sformatf("tbl%0d_rbusy", i), 32'(rbusy_o[0]), 32'(vecs[i].ebz));
      check($sformatf("tbl%0d_ready", i), 32'(rsv_ready_o), 32'(vecs[i].erdy));
      model_check();
      advance();
    end

    // Randomized traffic on a small address window to provoke conflicts.
    for (int n = 0; n < 400; n++) begin
      rst_n = ($urandom_range(0, 99) != 0);
      for (int p = 0; p < 2; p++) begin
        we[p]    = 1'($urandom_range(0, 1));
        waddr[p] = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
        wdata[p] = $urandom;
      end
      for (int r = 0; r < 3; r++) raddr[r] = 5'($urandom_range(0, 7));
      rsv_valid = 1'($urandom_range(0, 1));
      rsv_addr  = 5'($urandom_range(0, 7));
      flush     = ($urandom_range(0, 19) == 0);
      #1;
      model_check();
      advance();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
